// File: rtl/cond_code_unit_if.sv
// E-stage bundle between the execute pipeline and the condition-code unit.
// The master drives the ALU/control side. The slave returns the CC state and the condition result.
interface cond_code_unit_if #(
    parameter int unsigned WIDTH = 64
);
    logic             e_stall;
    logic             e_bubble;
    logic             set_cc;
    logic [1:0]       alu_fun;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic [3:0]       e_ifun;
    logic             m_exc;
    logic             w_exc;
    logic             zf;
    logic             sf;
    logic             of;
    logic             e_cnd;
    logic             cc_written;

    modport master (
        output e_stall, e_bubble, set_cc, alu_fun, alu_result, alu_overflow,
               e_ifun, m_exc, w_exc,
        input  zf, sf, of, e_cnd, cc_written
    );

    modport slave (
        input  e_stall, e_bubble, set_cc, alu_fun, alu_result, alu_overflow,
               e_ifun, m_exc, w_exc,
        output zf, sf, of, e_cnd, cc_written
    );
endinterface

// File: rtl/cond_code_unit.sv
// Y86-64 condition-code register (ZF/SF/OF) and jXX/cmovXX condition evaluation.
// The CC register is written by OPq in E. e_cnd is evaluated from the registered flags, with no bypass.
module cond_code_unit #(
    parameter int unsigned WIDTH  = 64,
    parameter logic        ZF_RST = 1'b1
) (
    input logic               clk,
    input logic               rst,
    cond_code_unit_if.slave   cc
);
    typedef enum logic [1:0] {
        FUN_ADD = 2'b00,
        FUN_SUB = 2'b01,
        FUN_AND = 2'b10,
        FUN_XOR = 2'b11
    } alu_fun_e;

    typedef enum logic [3:0] {
        C_ALWAYS = 4'd0,
        C_LE     = 4'd1,
        C_L      = 4'd2,
        C_E      = 4'd3,
        C_NE     = 4'd4,
        C_GE     = 4'd5,
        C_G      = 4'd6
    } cond_e;

    logic zf_q, sf_q, of_q, written_q;
    logic wr;
    logic lt;
    logic cnd;

    assign wr = cc.set_cc & ~cc.e_stall & ~cc.e_bubble & ~cc.m_exc & ~cc.w_exc;

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q      <= ZF_RST;
            sf_q      <= 1'b0;
            of_q      <= 1'b0;
            written_q <= 1'b0;
        end else begin
            written_q <= wr;
            if (wr) begin
                zf_q <= (cc.alu_result == '0);
                sf_q <= cc.alu_result[WIDTH-1];
                // An and/xor result cannot overflow, so the ALU overflow flag is ignored for those functions.
                of_q <= (cc.alu_fun == FUN_ADD || cc.alu_fun == FUN_SUB) ? cc.alu_overflow : 1'b0;
            end
        end
    end

    assign lt = sf_q ^ of_q;

    always_comb begin
        cnd = 1'b0;
        case (cc.e_ifun)
            C_ALWAYS: cnd = 1'b1;
            C_LE:     cnd = lt | zf_q;
            C_L:      cnd = lt;
            C_E:      cnd = zf_q;
            C_NE:     cnd = ~zf_q;
            C_GE:     cnd = ~lt;
            C_G:      cnd = ~lt & ~zf_q;
            default:  cnd = 1'b0;
        endcase
    end

    assign cc.zf         = zf_q;
    assign cc.sf         = sf_q;
    assign cc.of         = of_q;
    assign cc.cc_written = written_q;
    assign cc.e_cnd      = cnd;
endmodule
